gmux_clk_sel_ctrl: RTL and testbench
====================================

// Module: gmux_clk_sel_ctrl
// PURPOSE
//  Sequencer for one GMUX_CLK global-clock mux. Drives the SSEL source select and the four
//  quadrant static enables (TL/TR/BL/BR _SEN), plus the low-power _VLP pins when that
//  feature is compiled in. Switches SSEL between GCLKIN (0) and GHSCK (1) without glitches:
//  gate all quadrants, drain, flip SSEL, settle, then re-enable.
//  Sits in fabric beside each GMUX_CLK. _DEN/_DYNEN are tied 0 by the wrapper; they are not driven here.
// PARAMETERS
//  DRAIN_CYC   4  cycles SEN held 0 before SSEL flips (>=1)
//  SETTLE_CYC  2  cycles after SSEL flip before SEN is restored (>=1)
//  CNT_W       derived localparam, $clog2(max(DRAIN_CYC,SETTLE_CYC))+1
// PORTS
//  QCK        in   1  controller clock (free-running, not the muxed clock)
//  QRT        in   1  asynchronous reset, active-high
//  REQ_VALID  in   1  reconfiguration request
//  REQ_READY  out  1  controller idle; a request is accepted when REQ_VALID & REQ_READY
//  REQ_SRC    in   1  requested source: 0=GCLKIN, 1=GHSCK
//  REQ_QMASK  in   4  requested quadrant enables, bit order {BR,BL,TR,TL}
//  LP_REQ     in   1  low-power request (level)
//  SSEL       out  1  to GMUX_CLK.SSEL
//  SEN        out  4  to {BR,BL,TR,TL}_SEN
//  VLP        out  4  to {BR,BL,TR,TL}_VLP
//  DONE       out  1  one-cycle pulse when a request or LP exit completes
// BEHAVIOUR
//  Reset values (async on QRT, any state): SSEL=0, SEN=4'hF, VLP=0, DONE=0, REQ_READY=0, state IDLE.
//   These match the timed GCLKIN->IZ configuration. REQ_READY rises on the first QCK edge after QRT falls.
//  All outputs are registered. States: IDLE, GATE, DRAIN, SWITCH, SETTLE, ENABLE (+LP_*).
//  IDLE: REQ_READY=1. On accept, capture src/mask and drop REQ_READY on the next edge. Then:
//   - src==SSEL && mask==SEN: DONE pulses next cycle; stay IDLE (no gating).
//   - src==SSEL, mask differs: SEN<=mask and DONE in one cycle; return to IDLE.
//   - src!=SSEL: go to GATE.
//  GATE: SEN<=0; counter loads DRAIN_CYC-1; next state DRAIN.
//  DRAIN: decrement counter; at 0 go to SWITCH.
//  SWITCH: SSEL<=src; counter loads SETTLE_CYC-1; next state SETTLE.
//  SETTLE: decrement counter; at 0 go to ENABLE.
//  ENABLE: SEN<=mask; DONE=1 for this cycle; next state IDLE.
//  Switch timing, with the accept edge = edge 0:
//   - SEN=0 after edge 1.
//   - SSEL toggles after edge 2+DRAIN_CYC.
//   - SEN=mask and DONE after edge 3+DRAIN_CYC+SETTLE_CYC.
//  SSEL never changes while any SEN bit is 1.
//  mask=0 is legal: the switch completes and all quadrants stay off.
//  REQ_SRC/REQ_QMASK are sampled only at accept; later changes are ignored.
//  REQ_VALID while busy is held off by REQ_READY=0 (no queueing).
//  REQ_VALID and LP_REQ in the same IDLE cycle: the request wins; LP is evaluated on the next IDLE.
//  QRT mid-sequence: immediate return to reset values. The SEN=F/SSEL=0 jump is accepted as a reset event.
// CONFIGURATION
//  GMUX_CTRL_VLP_EN defined: LP_REQ=1 in IDLE (no request pending) runs this sequence:
//   - LP_GATE: SEN<=0, DRAIN_CYC cycles.
//   - LP_ON: VLP<=4'hF; hold while LP_REQ=1; REQ_READY=0.
//   - On LP_REQ=0: VLP<=0, wait SETTLE_CYC, restore the pre-LP SEN, pulse DONE, go to IDLE.
//  GMUX_CTRL_VLP_EN undefined: LP_REQ is ignored, VLP is constant 0, and no LP states exist.
// STRUCTURE
//  gmux_ctrl_pkg holds:
//   - the state enum;
//   - quadrant index constants QUAD_TL=0, QUAD_TR=1, QUAD_BL=2, QUAD_BR=3, and QMASK_ALL=4'hF;
//   - the reset constants for SEN, SSEL and VLP.
//  Sub-module gmux_ctrl_dcnt: loadable CNT_W-bit down-counter with a zero flag, used for DRAIN and SETTLE.
// TESTING
//  1 Reset: QRT pulse mid-DRAIN -> SSEL=0, SEN=F, VLP=0, REQ_READY=0 during QRT and 1 one cycle after release.
//  2 Switch: DRAIN_CYC=4, SETTLE_CYC=2, REQ_SRC=1, mask=F at edge 0 -> SEN=0 @1, SSEL=1 @6,
//    SEN=F + DONE @9; assert SSEL is stable whenever SEN!=0.
//  3 Mask-only: SSEL=0, request src=0 mask=4'b0101 -> SEN=5 and DONE next cycle, SSEL unchanged, no SEN=0 cycle.
//  4 No-op and back-pressure: identical request -> DONE only. REQ_VALID held during a switch
//    -> second request accepted only after DONE; its src/mask are taken at that acceptance.
//  5 mask=0 switch to GHSCK -> SSEL=1, SEN=0 at DONE; a following src=0, mask=F request restores GCLKIN with all quadrants on.
//  6 (VLP_EN) LP_REQ=1 for 10 cycles from SEN=F -> SEN=0, then VLP=F;
//    LP_REQ=0 -> VLP=0, SEN=F after SETTLE_CYC with DONE. Without the macro: VLP stays 0 and SEN is unaffected.

Source files
------------

// File: rtl/gmux_ctrl_pkg.sv
// Shared types and constants for the GMUX_CLK select controller.
// Optional low-power sequencing is enabled by defining GMUX_CTRL_VLP_EN.
package gmux_ctrl_pkg;

    localparam int unsigned QUAD_TL = 0;
    localparam int unsigned QUAD_TR = 1;
    localparam int unsigned QUAD_BL = 2;
    localparam int unsigned QUAD_BR = 3;
    localparam int unsigned QUAD_N  = 4;

    localparam logic [QUAD_N-1:0] QMASK_ALL = 4'hF;

    // Reset values match the timed GCLKIN configuration
    localparam logic [QUAD_N-1:0] SEN_RST  = QMASK_ALL;
    localparam logic              SSEL_RST = 1'b0;
    localparam logic [QUAD_N-1:0] VLP_RST  = 4'h0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GATE,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE,
        ST_ENABLE
`ifdef GMUX_CTRL_VLP_EN
        ,
        ST_LP_GATE,
        ST_LP_DRAIN,
        ST_LP_ON,
        ST_LP_SETTLE
`endif
    } gmux_state_e;

endpackage

// File: rtl/gmux_ctrl_dcnt.sv
// Loadable down-counter with zero flag; times the drain and settle windows.
module gmux_ctrl_dcnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/gmux_clk_sel_ctrl.sv
// Glitch-free source-select sequencer for one GMUX_CLK: gate quadrants,
// drain, flip SSEL, settle, re-enable. Defining GMUX_CTRL_VLP_EN adds the
// low-power entry/exit sequence driving the _VLP pins.
module gmux_clk_sel_ctrl
    import gmux_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       QCK,
    input  logic       QRT,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_SRC,
    input  logic [3:0] REQ_QMASK,
    input  logic       LP_REQ,
    output logic       SSEL,
    output logic [3:0] SEN,
    output logic [3:0] VLP,
    output logic       DONE
);

    localparam int unsigned CNT_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    gmux_state_e state_q, state_d;

    logic        ssel_q, ssel_d;
    logic [3:0]  sen_q, sen_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        src_q, src_d;
    logic [3:0]  mask_q, mask_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero_c;

`ifdef GMUX_CTRL_VLP_EN
    logic [3:0]  vlp_q, vlp_d;
`endif

    gmux_ctrl_dcnt #(
        .CNT_W (CNT_W)
    ) u_dcnt (
        .clk      (QCK),
        .rst      (QRT),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // State register
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode; mask path (src==SSEL) reuses ENABLE
    always_comb begin
        state_d      = state_q;
        ssel_d       = ssel_q;
        sen_d        = sen_q;
        src_d        = src_q;
        mask_d       = mask_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef GMUX_CTRL_VLP_EN
        vlp_d        = vlp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    src_d   = REQ_SRC;
                    mask_d  = REQ_QMASK;
                    state_d = (REQ_SRC == ssel_q) ? ST_ENABLE : ST_GATE;
                end
`ifdef GMUX_CTRL_VLP_EN
                else if (LP_REQ && !REQ_VALID) begin
                    mask_d  = sen_q;
                    state_d = ST_LP_GATE;
                end
`endif
            end
            ST_GATE: begin
                sen_d        = '0;
                cnt_load     = 1'b1;
                cnt_load_val = DRAIN_LD;
                state_d      = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_zero_c) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SWITCH: begin
                ssel_d       = src_q;
                cnt_load     = 1'b1;
                cnt_load_val = SETTLE_LD;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_zero_c) begin
                    state_d = ST_ENABLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ENABLE: begin
                sen_d   = mask_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef GMUX_CTRL_VLP_EN
            ST_LP_GATE: begin
                sen_d        = '0;
                cnt_load     = 1'b1;
                cnt_load_val = DRAIN_LD;
                state_d      = ST_LP_DRAIN;
            end
            ST_LP_DRAIN: begin
                if (cnt_zero_c) begin
                    vlp_d   = QMASK_ALL;
                    state_d = ST_LP_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LP_ON: begin
                if (!LP_REQ) begin
                    vlp_d        = VLP_RST;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LD;
                    state_d      = ST_LP_SETTLE;
                end
            end
            ST_LP_SETTLE: begin
                if (cnt_zero_c) begin
                    state_d = ST_ENABLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Output and request-capture registers
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            ssel_q  <= SSEL_RST;
            sen_q   <= SEN_RST;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            src_q   <= SSEL_RST;
            mask_q  <= SEN_RST;
        end else begin
            ssel_q  <= ssel_d;
            sen_q   <= sen_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
        end
    end

`ifdef GMUX_CTRL_VLP_EN
    // Low-power pin register
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            vlp_q <= VLP_RST;
        end else begin
            vlp_q <= vlp_d;
        end
    end

    assign VLP = vlp_q;
`else
    logic unused_lp_req;
    assign unused_lp_req = LP_REQ;
    assign VLP           = VLP_RST;
`endif

    assign SSEL      = ssel_q;
    assign SEN       = sen_q;
    assign DONE      = done_q;
    assign REQ_READY = ready_q;

endmodule

// File: tb/tb_gmux_clk_sel_ctrl.sv
// Self-checking bench for gmux_clk_sel_ctrl: directed scenarios plus random
// traffic against a timeline-queue reference model. Honours GMUX_CTRL_VLP_EN.
module tb_gmux_clk_sel_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    typedef struct packed {
        logic       ssel;
        logic [3:0] sen;
        logic [3:0] vlp;
        logic       done;
        logic       ready;
    } snap_t;

    logic       qck = 1'b0;
    logic       qrt;
    logic       req_valid;
    logic       req_ready;
    logic       req_src;
    logic [3:0] req_qmask;
    logic       lp_req;
    logic       ssel;
    logic [3:0] sen;
    logic [3:0] vlp;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    snap_t      cur;
    snap_t      q[$];
    logic       lp_on;
    logic [3:0] lp_saved;
    logic       prev_ssel;
    logic [3:0] prev_sen;

    gmux_clk_sel_ctrl #(
        .DRAIN_CYC  (D),
        .SETTLE_CYC (S)
    ) dut (
        .QCK       (qck),
        .QRT       (qrt),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_SRC   (req_src),
        .REQ_QMASK (req_qmask),
        .LP_REQ    (lp_req),
        .SSEL      (ssel),
        .SEN       (sen),
        .VLP       (vlp),
        .DONE      (done)
    );

    always #5 qck = ~qck;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic snap_t mk(input logic ss, input logic [3:0] se, input logic [3:0] vl,
                                 input logic dn, input logic rd);
        snap_t t;
        t.ssel = ss; t.sen = se; t.vlp = vl; t.done = dn; t.ready = rd;
        return t;
    endfunction

    // Model: on each edge either replay a precomputed timeline or apply idle rules
    task automatic model_step();
        if (qrt) begin
            cur   = mk(1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
            lp_on = 1'b0;
            q.delete();
            return;
        end
        if (q.size() == 0) begin
            if (lp_on) begin
                if (!lp_req) begin
                    for (int i = 0; i <= int'(S); i++) q.push_back(mk(cur.ssel, 4'h0, 4'h0, 1'b0, 1'b0));
                    q.push_back(mk(cur.ssel, lp_saved, 4'h0, 1'b1, 1'b1));
                    lp_on = 1'b0;
                end
            end else if (req_valid && cur.ready) begin
                q.push_back(mk(cur.ssel, cur.sen, 4'h0, 1'b0, 1'b0));
                if (req_src != cur.ssel) begin
                    for (int i = 1; i <= int'(D) + 1; i++) q.push_back(mk(cur.ssel, 4'h0, 4'h0, 1'b0, 1'b0));
                    for (int i = 0; i <= int'(S); i++) q.push_back(mk(req_src, 4'h0, 4'h0, 1'b0, 1'b0));
                end
                q.push_back(mk(req_src, req_qmask, 4'h0, 1'b1, 1'b1));
            end
`ifdef GMUX_CTRL_VLP_EN
            else if (lp_req && !req_valid) begin
                lp_saved = cur.sen;
                lp_on    = 1'b1;
                q.push_back(mk(cur.ssel, cur.sen, 4'h0, 1'b0, 1'b0));
                for (int i = 1; i <= int'(D); i++) q.push_back(mk(cur.ssel, 4'h0, 4'h0, 1'b0, 1'b0));
                q.push_back(mk(cur.ssel, 4'h0, 4'hF, 1'b0, 1'b0));
            end
`endif
        end
        if (q.size() != 0) begin
            cur = q.pop_front();
        end else begin
            cur.done  = 1'b0;
            cur.ready = !lp_on;
        end
    endtask

    task automatic compare_all();
        check("ssel", 32'(ssel), 32'(cur.ssel));
        check("sen", 32'(sen), 32'(cur.sen));
        check("vlp", 32'(vlp), 32'(cur.vlp));
        check("done", 32'(done), 32'(cur.done));
        check("ready", 32'(req_ready), 32'(cur.ready));
        if (!qrt) begin
            check("ssel_stable", 32'((ssel != prev_ssel) && ((prev_sen != 4'h0) || (sen != 4'h0))), 32'd0);
        end
        prev_ssel = ssel;
        prev_sen  = sen;
    endtask

    task automatic tick(input logic v, input logic s, input logic [3:0] m, input logic lp);
        req_valid = v;
        req_src   = s;
        req_qmask = m;
        lp_req    = lp;
        model_step();
        @(negedge qck);
        compare_all();
    endtask

    task automatic idle_wait();
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cur.ready && q.size() == 0 && !lp_on) begin
                ok = 1'b1;
                break;
            end
            tick(1'b0, 1'b0, 4'h0, 1'b0);
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b0);
            if (done) begin
                lat = k;
                break;
            end
        end
        check(tag, 32'(lat != 0), 32'd1);
    endtask

    initial begin
        int         lat;
        logic       s2;
        logic [3:0] m2;
        bit         seen;
        logic       lp_lvl;

        qrt = 1'b1; req_valid = 1'b0; req_src = 1'b0; req_qmask = 4'h0; lp_req = 1'b0;
        lp_on = 1'b0; lp_saved = 4'hF; prev_ssel = 1'b0; prev_sen = 4'hF;
        model_step();
        @(negedge qck);
        compare_all();
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        qrt = 1'b0;
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Reset mid-drain
        tick(1'b1, 1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("in_drain_sen", 32'(sen), 32'd0);
        qrt = 1'b1;
        model_step();
        #1;
        compare_all();
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        qrt = 1'b0;
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("rst_release_ready", 32'(req_ready), 32'd1);

        // Full switch to GHSCK with latency check
        idle_wait();
        tick(1'b1, 1'b1, 4'hF, 1'b0);
        wait_done("sw_done", lat);
        check("sw_latency", 32'(lat), 32'(3 + D + S));
        check("sw_ssel", 32'(ssel), 32'd1);
        check("sw_sen", 32'(sen), 32'hF);

        // Back to GCLKIN, then mask-only change
        tick(1'b1, 1'b0, 4'hF, 1'b0);
        wait_done("back_done", lat);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        tick(1'b1, 1'b0, 4'b0101, 1'b0);
        check("mo_ready_drop", 32'(req_ready), 32'd0);
        check("mo_sen_hold", 32'(sen), 32'hF);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("mo_sen", 32'(sen), 32'h5);
        check("mo_done", 32'(done), 32'd1);
        check("mo_ssel", 32'(ssel), 32'd0);

        // Identical request: DONE only
        tick(1'b1, 1'b0, 4'b0101, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("noop_done", 32'(done), 32'd1);
        check("noop_sen", 32'(sen), 32'h5);

        // Back-pressure: VALID held with changing payload during a switch
        tick(1'b1, 1'b1, 4'hF, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'($urandom), 4'($urandom), 1'b0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_first_done", 32'(seen), 32'd1);
        s2 = 1'($urandom);
        m2 = 4'($urandom);
        tick(1'b1, s2, m2, 1'b0);
        check("bp_accept", 32'(req_ready), 32'd0);
        wait_done("bp_second_done", lat);
        check("bp_ssel", 32'(ssel), 32'(s2));
        check("bp_sen", 32'(sen), 32'(m2));

        // mask=0 switch to GHSCK, then restore GCLKIN with all quadrants on
        idle_wait();
        if (ssel) begin
            tick(1'b1, 1'b0, 4'hF, 1'b0);
            wait_done("pre_m0_done", lat);
            tick(1'b0, 1'b0, 4'h0, 1'b0);
        end
        tick(1'b1, 1'b1, 4'h0, 1'b0);
        wait_done("m0_done", lat);
        check("m0_ssel", 32'(ssel), 32'd1);
        check("m0_sen", 32'(sen), 32'd0);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        tick(1'b1, 1'b0, 4'hF, 1'b0);
        wait_done("m0_restore_done", lat);
        check("m0_restore_ssel", 32'(ssel), 32'd0);
        check("m0_restore_sen", 32'(sen), 32'hF);

        // Low-power request for 10 cycles from SEN=F
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 4'h0, 1'b1);
`ifdef GMUX_CTRL_VLP_EN
        check("lp_vlp_on", 32'(vlp), 32'hF);
        check("lp_sen_off", 32'(sen), 32'h0);
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b0);
            if (k == 1) check("lp_vlp_drop", 32'(vlp), 32'h0);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("lp_exit_latency", 32'(lat), 32'(S + 2));
        check("lp_sen_restore", 32'(sen), 32'hF);
`else
        check("nolp_vlp", 32'(vlp), 32'h0);
        check("nolp_sen", 32'(sen), 32'hF);
        check("nolp_ready", 32'(req_ready), 32'd1);
`endif

        // Random traffic
        lp_lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic       v;
            logic       s;
            logic [3:0] m;
            if ($urandom_range(0, 9) == 0) lp_lvl = ~lp_lvl;
            v = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 3) == 0) begin
                s = cur.ssel;
                m = ($urandom_range(0, 1) == 0) ? cur.sen : 4'($urandom);
            end else begin
                s = 1'($urandom);
                m = 4'($urandom);
            end
            tick(v, s, m, lp_lvl);
        end
        idle_wait();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
